// File: rtl/gin_pe_fifo_if.sv
// rtl/gin_pe_fifo_if.sv - X-bus ingress and PE egress handshake bundle for gin_pe_fifo
interface gin_pe_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  enable_in;
  logic                  ready_out;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;
  logic                  last_out;

  modport master (
    output data_in, enable_in, ready_in,
    input  ready_out, data_out, valid_out, last_out
  );

  modport slave (
    input  data_in, enable_in, ready_in,
    output ready_out, data_out, valid_out, last_out
  );
endinterface

// File: rtl/gin_pe_fifo.sv
// rtl/gin_pe_fifo.sv - per-PE GIN packet FIFO that unpacks packets into words LSB-first
// Optional occupancy output enabled by defining GIN_PE_FIFO_OCC_EN.
module gin_pe_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  gin_pe_fifo_if.slave               gin
`ifdef GIN_PE_FIFO_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
  localparam int WPE = DATA_WIDTH / WORD_WIDTH;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int WW  = (WPE > 1) ? $clog2(WPE) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [WW-1:0] WLAST  = WW'(WPE - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WW-1:0]         widx_q, widx_d;

  logic                  ready;
  logic                  valid;
  logic                  push;
  logic                  pop;
  logic                  retire;
  logic [DATA_WIDTH-1:0] head;

  always_comb begin
    ready    = (count_q != FULL_C);
    valid    = (count_q != '0);
    head     = mem_q[rd_ptr_q];
    push     = gin.enable_in && ready;
    pop      = valid && gin.ready_in;
    retire   = pop && (widx_q == WLAST);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    widx_d   = widx_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      widx_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = gin.data_in;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        if (retire) begin
          widx_d   = '0;
          rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
          widx_d   = widx_q + WW'(1);
        end
      end
      // A full FIFO never pushes, so push-and-retire only happens below DEPTH.
      case ({push, retire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      widx_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      widx_q   <= widx_d;
    end
  end

  assign gin.ready_out = ready;
  assign gin.valid_out = valid;
  assign gin.last_out  = valid && (widx_q == WLAST);
  assign gin.data_out  = head[widx_q*WORD_WIDTH +: WORD_WIDTH];

`ifdef GIN_PE_FIFO_OCC_EN
  assign occupancy = count_q;
`endif
endmodule

// File: tb/tb_gin_pe_fifo.sv
// tb/tb_gin_pe_fifo.sv - directed plus randomized bench for gin_pe_fifo against a queue model
module tb_gin_pe_fifo;
  localparam int DW    = 64;
  localparam int WDW   = 16;
  localparam int DEPTH = 4;
  localparam int WPE   = DW / WDW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  logic clear;
`ifdef GIN_PE_FIFO_OCC_EN
  logic [CW-1:0] occupancy;
`endif

  gin_pe_fifo_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WDW)) gin ();

  gin_pe_fifo #(.DATA_WIDTH(DW), .WORD_WIDTH(WDW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .gin       (gin.slave)
`ifdef GIN_PE_FIFO_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] pkt_q[$];
  int            widx_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [DW-1:0] hp;
    bit            v;
    v = (pkt_q.size() != 0);
    chk("ready_out", 64'(gin.ready_out), 64'(pkt_q.size() != DEPTH));
    chk("valid_out", 64'(gin.valid_out), 64'(v));
    chk("last_out", 64'(gin.last_out), 64'(v && (widx_m == WPE - 1)));
    if (v) begin
      hp = pkt_q[0];
      chk("data_out", 64'(gin.data_out), 64'(hp[widx_m*WDW +: WDW]));
    end
`ifdef GIN_PE_FIFO_OCC_EN
    chk("occupancy", 64'(occupancy), 64'(pkt_q.size()));
`endif
  endtask

  // One clock: apply inputs, check current outputs, clock, then advance the model.
  task automatic drive(input logic en, input logic [DW-1:0] d, input logic rdy, input logic clr);
    bit do_push, do_pop;
    gin.enable_in = en;
    gin.data_in   = d;
    gin.ready_in  = rdy;
    clear         = clr;
    #1;
    check_outputs();
    do_push = en && (pkt_q.size() != DEPTH);
    do_pop  = (pkt_q.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (clr) begin
      pkt_q.delete();
      widx_m = 0;
    end else begin
      if (do_pop) begin
        if (widx_m == WPE - 1) begin
          void'(pkt_q.pop_front());
          widx_m = 0;
        end else begin
          widx_m++;
        end
      end
      if (do_push) pkt_q.push_back(d);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drain();
    for (int i = 0; i < 200 && pkt_q.size() != 0; i++) drive(1'b0, '0, 1'b1, 1'b0);
    chk("drained", 64'(pkt_q.size()), 64'd0);
  endtask

  initial begin
    reset         = 1'b0;
    clear         = 1'b0;
    gin.enable_in = 1'b0;
    gin.data_in   = '0;
    gin.ready_in  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(gin.ready_out), 64'd1);
    chk("rst_valid", 64'(gin.valid_out), 64'd0);
    chk("rst_last", 64'(gin.last_out), 64'd0);
    chk("rst_data", 64'(gin.data_out), 64'd0);
`ifdef GIN_PE_FIFO_OCC_EN
    chk("rst_occ", 64'(occupancy), 64'd0);
`endif
    reset = 1'b1;

    // Unpack order, LSB word first
    drive(1'b1, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("unpack_data", 64'(gin.data_out), 64'(k));
      chk("unpack_last", 64'(gin.last_out), 64'(k == 4));
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    chk("unpack_empty", 64'(gin.valid_out), 64'd0);

    // Fill to full, drop a fifth packet, free a slot by retiring one packet
    for (int k = 0; k < 4; k++) drive(1'b1, rnd64(), 1'b0, 1'b0);
    chk("full_ready", 64'(gin.ready_out), 64'd0);
    drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1, 1'b0);
    chk("full_ready_after", 64'(gin.ready_out), 64'd1);
    drain();

    // Push on the same cycle as a last-word pop keeps count at 2
    drive(1'b1, rnd64(), 1'b0, 1'b0);
    drive(1'b1, rnd64(), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, rnd64(), 1'b1, 1'b0);
    chk("simul_valid", 64'(gin.valid_out), 64'd1);
`ifdef GIN_PE_FIFO_OCC_EN
    chk("simul_occ", 64'(occupancy), 64'd2);
`endif
    for (int k = 0; k < 40; k++) drive(1'(k % 4 == 3), rnd64(), 1'b1, 1'b0);
    drain();

    // Clear mid-packet with a concurrent push
    for (int k = 0; k < 3; k++) drive(1'b1, rnd64(), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, rnd64(), 1'b0, 1'b1);
    chk("clear_valid", 64'(gin.valid_out), 64'd0);
    chk("clear_ready", 64'(gin.ready_out), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0);

    // Stall mid-packet for 5 cycles
    drive(1'b1, rnd64(), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Randomized traffic with occasional clears
    for (int k = 0; k < 3000; k++)
      drive(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0));

    // Asynchronous reset mid-traffic
    drive(1'b1, rnd64(), 1'b0, 1'b0);
    drive(1'b1, rnd64(), 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ready", 64'(gin.ready_out), 64'd1);
    chk("arst_valid", 64'(gin.valid_out), 64'd0);
    chk("arst_last", 64'(gin.last_out), 64'd0);
    chk("arst_data", 64'(gin.data_out), 64'd0);
`ifdef GIN_PE_FIFO_OCC_EN
    chk("arst_occ", 64'(occupancy), 64'd0);
`endif
    pkt_q.delete();
    widx_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 64'h0008_0007_0006_0005, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
